// File: rtl/sprite_compositor_if.sv
// Bus between the raster timing side, the external sprite ROMs and sprite_compositor.
// Defining SPRITE_MIRROR_EN adds the per-sprite horizontal flip input spr_flip_x.
interface sprite_compositor_if #(
    parameter int NUM_SPR = 4,
    parameter int COORD_W = 11,
    parameter int PIX_W   = 12,
    parameter int ADDR_W  = 14
);
    logic                       frame_start;
    logic [NUM_SPR-1:0]         spr_en;
    logic [NUM_SPR*COORD_W-1:0] spr_pos_x;
    logic [NUM_SPR*COORD_W-1:0] spr_pos_y;
`ifdef SPRITE_MIRROR_EN
    logic [NUM_SPR-1:0]         spr_flip_x;
`endif
    logic [COORD_W-1:0]         curr_x;
    logic [COORD_W-1:0]         curr_y;
    logic                       pix_valid;
    logic [NUM_SPR*ADDR_W-1:0]  rom_addr;
    logic [NUM_SPR*PIX_W-1:0]   rom_data;
    logic [3:0]                 draw_r;
    logic [3:0]                 draw_g;
    logic [3:0]                 draw_b;
    logic                       draw_valid;
    logic [NUM_SPR-1:0]         coll_status;

    // Raster / ROM side.
    modport master (
`ifdef SPRITE_MIRROR_EN
        output spr_flip_x,
`endif
        output frame_start, spr_en, spr_pos_x, spr_pos_y,
        output curr_x, curr_y, pix_valid, rom_data,
        input  rom_addr, draw_r, draw_g, draw_b, draw_valid, coll_status
    );

    // Compositor side.
    modport slave (
`ifdef SPRITE_MIRROR_EN
        input  spr_flip_x,
`endif
        input  frame_start, spr_en, spr_pos_x, spr_pos_y,
        input  curr_x, curr_y, pix_valid, rom_data,
        output rom_addr, draw_r, draw_g, draw_b, draw_valid, coll_status
    );
endinterface

// File: rtl/sprite_compositor.sv
// N-sprite fixed-priority compositor: address -> ROM wait -> compose, with per-frame collision flags.
// Optional horizontal mirroring is enabled by defining SPRITE_MIRROR_EN.
module sprite_compositor #(
    parameter int NUM_SPR  = 4,
    parameter int COORD_W  = 11,
    parameter int PIX_W    = 12,
    parameter int SPR_W    = 90,
    parameter int SPR_H    = 26,
    parameter int ADDR_W   = 14,
    parameter int SCREEN_W = 1440,
    parameter int SCREEN_H = 900,
    parameter int BORDER   = 10,
    parameter logic [PIX_W-1:0] TRANSP_KEY = 12'h000
) (
    input logic                clk,
    input logic                rst,
    sprite_compositor_if.slave bus
);
    localparam int CW1 = COORD_W + 1;
    localparam logic signed [CW1-1:0] SPR_W_S = CW1'(SPR_W);
    localparam logic signed [CW1-1:0] SPR_H_S = CW1'(SPR_H);
    localparam logic [COORD_W-1:0]    X_LO    = COORD_W'(BORDER);
    localparam logic [COORD_W-1:0]    X_HI    = COORD_W'(SCREEN_W - 1 - BORDER);
    localparam logic [COORD_W-1:0]    Y_LO    = COORD_W'(BORDER);
    localparam logic [COORD_W-1:0]    Y_HI    = COORD_W'(SCREEN_H - 1 - BORDER);

    // dx/dy are only meaningful (non-negative, in range) when the pixel is inside the box.
    function automatic logic [ADDR_W-1:0] sprite_addr(input logic signed [CW1-1:0] dx,
                                                      input logic signed [CW1-1:0] dy,
                                                      input logic                  flip);
        logic [31:0] col;
        logic [31:0] row;
        logic [31:0] full;
        col  = flip ? (32'(SPR_W - 1) - 32'($unsigned(dx))) : 32'($unsigned(dx));
        row  = 32'($unsigned(dy));
        full = row * 32'(SPR_W) + col;
        return full[ADDR_W-1:0];
    endfunction

    function automatic logic [PIX_W-1:0] background(input logic [COORD_W-1:0] x,
                                                    input logic [COORD_W-1:0] y);
        if (x < X_LO || x > X_HI || y < Y_LO || y > Y_HI)
            return '1;
        return '0;
    endfunction

    logic [NUM_SPR-1:0]         en_sh_q, en_sh_d;
    logic [NUM_SPR*COORD_W-1:0] pos_x_sh_q, pos_x_sh_d;
    logic [NUM_SPR*COORD_W-1:0] pos_y_sh_q, pos_y_sh_d;
    logic [NUM_SPR-1:0]         flip_sh;

    logic signed [CW1-1:0]      dx [NUM_SPR];
    logic signed [CW1-1:0]      dy [NUM_SPR];

    logic [NUM_SPR-1:0]         inbox_p1_q, inbox_p1_d;
    logic                       vld_p1_q, vld_p1_d;
    logic [COORD_W-1:0]         x_p1_q, x_p1_d;
    logic [COORD_W-1:0]         y_p1_q, y_p1_d;
    logic [NUM_SPR*ADDR_W-1:0]  rom_addr_p1_q, rom_addr_p1_d;

    logic [NUM_SPR-1:0]         inbox_p2_q, inbox_p2_d;
    logic                       vld_p2_q, vld_p2_d;
    logic [COORD_W-1:0]         x_p2_q, x_p2_d;
    logic [COORD_W-1:0]         y_p2_q, y_p2_d;

    logic [NUM_SPR-1:0]         opaque;
    logic [NUM_SPR-1:0]         hits;
    logic [PIX_W-1:0]           fg_pix;
    logic [PIX_W-1:0]           rgb_p3_q, rgb_p3_d;
    logic                       vld_p3_q, vld_p3_d;
    logic [NUM_SPR-1:0]         coll_work_q, coll_work_d;
    logic [NUM_SPR-1:0]         coll_status_q, coll_status_d;

`ifdef SPRITE_MIRROR_EN
    logic [NUM_SPR-1:0]         flip_sh_q, flip_sh_d;

    always_comb begin
        flip_sh_d = bus.frame_start ? bus.spr_flip_x : flip_sh_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) flip_sh_q <= '0;
        else      flip_sh_q <= flip_sh_d;
    end

    assign flip_sh = flip_sh_q;
`else
    assign flip_sh = '0;
`endif

    always_comb begin
        // Shadow registers: sprite state only changes at frame boundaries.
        en_sh_d    = en_sh_q;
        pos_x_sh_d = pos_x_sh_q;
        pos_y_sh_d = pos_y_sh_q;
        if (bus.frame_start) begin
            en_sh_d    = bus.spr_en;
            pos_x_sh_d = bus.spr_pos_x;
            pos_y_sh_d = bus.spr_pos_y;
        end

        // S1: box test and ROM address
        vld_p1_d      = bus.pix_valid;
        x_p1_d        = bus.curr_x;
        y_p1_d        = bus.curr_y;
        rom_addr_p1_d = rom_addr_p1_q;
        for (int i = 0; i < NUM_SPR; i++) begin
            dx[i] = $signed({1'b0, bus.curr_x}) - $signed({1'b0, pos_x_sh_q[i*COORD_W +: COORD_W]});
            dy[i] = $signed({1'b0, bus.curr_y}) - $signed({1'b0, pos_y_sh_q[i*COORD_W +: COORD_W]});
            inbox_p1_d[i] = en_sh_q[i] && bus.pix_valid
                            && !dx[i][CW1-1] && (dx[i] < SPR_W_S)
                            && !dy[i][CW1-1] && (dy[i] < SPR_H_S);
            if (inbox_p1_d[i])
                rom_addr_p1_d[i*ADDR_W +: ADDR_W] = sprite_addr(dx[i], dy[i], flip_sh[i]);
        end

        // S2: sideband waits for the ROM read
        inbox_p2_d = inbox_p1_q;
        vld_p2_d   = vld_p1_q;
        x_p2_d     = x_p1_q;
        y_p2_d     = y_p1_q;

        // S3: priority select, background and collision detection
        for (int i = 0; i < NUM_SPR; i++)
            opaque[i] = inbox_p2_q[i] && (bus.rom_data[i*PIX_W +: PIX_W] != TRANSP_KEY);
        fg_pix = '0;
        for (int i = NUM_SPR - 1; i >= 0; i--)
            if (opaque[i]) fg_pix = bus.rom_data[i*PIX_W +: PIX_W];
        for (int i = 0; i < NUM_SPR; i++)
            hits[i] = opaque[i] && |(opaque & ~(NUM_SPR'(1) << i));

        vld_p3_d = vld_p2_q;
        if (!vld_p2_q)
            rgb_p3_d = '0;
        else if (|opaque)
            rgb_p3_d = fg_pix;
        else
            rgb_p3_d = background(x_p2_q, y_p2_q);

        // Hits landing in the frame_start cycle still belong to the frame being closed.
        if (bus.frame_start) begin
            coll_status_d = coll_work_q | hits;
            coll_work_d   = '0;
        end else begin
            coll_status_d = coll_status_q;
            coll_work_d   = coll_work_q | hits;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            en_sh_q       <= '0;
            pos_x_sh_q    <= '0;
            pos_y_sh_q    <= '0;
            inbox_p1_q    <= '0;
            vld_p1_q      <= 1'b0;
            x_p1_q        <= '0;
            y_p1_q        <= '0;
            rom_addr_p1_q <= '0;
            inbox_p2_q    <= '0;
            vld_p2_q      <= 1'b0;
            x_p2_q        <= '0;
            y_p2_q        <= '0;
            rgb_p3_q      <= '0;
            vld_p3_q      <= 1'b0;
            coll_work_q   <= '0;
            coll_status_q <= '0;
        end else begin
            en_sh_q       <= en_sh_d;
            pos_x_sh_q    <= pos_x_sh_d;
            pos_y_sh_q    <= pos_y_sh_d;
            inbox_p1_q    <= inbox_p1_d;
            vld_p1_q      <= vld_p1_d;
            x_p1_q        <= x_p1_d;
            y_p1_q        <= y_p1_d;
            rom_addr_p1_q <= rom_addr_p1_d;
            inbox_p2_q    <= inbox_p2_d;
            vld_p2_q      <= vld_p2_d;
            x_p2_q        <= x_p2_d;
            y_p2_q        <= y_p2_d;
            rgb_p3_q      <= rgb_p3_d;
            vld_p3_q      <= vld_p3_d;
            coll_work_q   <= coll_work_d;
            coll_status_q <= coll_status_d;
        end
    end

    assign bus.rom_addr    = rom_addr_p1_q;
    assign bus.draw_r      = rgb_p3_q[PIX_W-1 -: 4];
    assign bus.draw_g      = rgb_p3_q[PIX_W-5 -: 4];
    assign bus.draw_b      = rgb_p3_q[PIX_W-9 -: 4];
    assign bus.draw_valid  = vld_p3_q;
    assign bus.coll_status = coll_status_q;
endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor with a behavioural 1-cycle-latency ROM per sprite.
module tb_sprite_compositor;
    localparam int NUM_SPR = 4;
    localparam int COORD_W = 11;
    localparam int PIX_W   = 12;
    localparam int ADDR_W  = 14;
    localparam int DEPTH   = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    logic [PIX_W-1:0] rom_mem [NUM_SPR][DEPTH];

    always #5 clk = ~clk;

    sprite_compositor_if #(.NUM_SPR(NUM_SPR), .COORD_W(COORD_W), .PIX_W(PIX_W), .ADDR_W(ADDR_W)) bus ();

    sprite_compositor #(.NUM_SPR(NUM_SPR), .COORD_W(COORD_W), .PIX_W(PIX_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(posedge clk) begin
        for (int i = 0; i < NUM_SPR; i++)
            bus.rom_data[i*PIX_W +: PIX_W] <= rom_mem[i][bus.rom_addr[i*ADDR_W +: ADDR_W]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pos(input int i, input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
        bus.spr_pos_x[i*COORD_W +: COORD_W] = x;
        bus.spr_pos_y[i*COORD_W +: COORD_W] = y;
    endtask

    task automatic pulse_frame();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
    endtask

    // One pixel through the 3-stage pipe; addr_s1 is rom_addr right after S1.
    task automatic apply(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y, input logic v,
                         output logic [NUM_SPR*ADDR_W-1:0] addr_s1);
        bus.curr_x    = x;
        bus.curr_y    = y;
        bus.pix_valid = v;
        tick();
        addr_s1       = bus.rom_addr;
        bus.pix_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            bus.frame_start = 1'($urandom);
            bus.spr_en      = 4'($urandom);
            bus.spr_pos_x   = 44'({$urandom, $urandom});
            bus.spr_pos_y   = 44'({$urandom, $urandom});
            bus.curr_x      = 11'($urandom);
            bus.curr_y      = 11'($urandom);
            bus.pix_valid   = 1'($urandom);
            tick();
        end
        checks++;
        if ({bus.draw_r, bus.draw_g, bus.draw_b} !== 12'h000) begin
            failures++; $display("FAIL reset_rgb got=%h want=000", {bus.draw_r, bus.draw_g, bus.draw_b});
        end
        checks++;
        if (bus.draw_valid !== 1'b0) begin
            failures++; $display("FAIL reset_draw_valid got=%b want=0", bus.draw_valid);
        end
        checks++;
        if (bus.coll_status !== 4'b0000) begin
            failures++; $display("FAIL reset_coll got=%b want=0000", bus.coll_status);
        end
        checks++;
        if (bus.rom_addr !== '0) begin
            failures++; $display("FAIL reset_rom_addr got=%h want=0", bus.rom_addr);
        end
        bus.frame_start = 1'b0;
        bus.spr_en      = '0;
        bus.spr_pos_x   = '0;
        bus.spr_pos_y   = '0;
        bus.pix_valid   = 1'b0;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_sprite();
        logic [NUM_SPR*ADDR_W-1:0] a;
        set_pos(0, 11'd100, 11'd50);
        bus.spr_en = 4'b0001;
        pulse_frame();

        apply(11'd100, 11'd50, 1'b1, a);
        checks++;
        if (a[ADDR_W-1:0] !== 14'd0) begin
            failures++; $display("FAIL single_addr_first got=%0d want=0", a[ADDR_W-1:0]);
        end
        checks++;
        if ({bus.draw_r, bus.draw_g, bus.draw_b, bus.draw_valid} !== {12'h001, 1'b1}) begin
            failures++; $display("FAIL single_rgb_first got=%h/%b want=001/1", {bus.draw_r, bus.draw_g, bus.draw_b}, bus.draw_valid);
        end

        apply(11'd189, 11'd75, 1'b1, a);
        checks++;
        if (a[ADDR_W-1:0] !== 14'd2339) begin
            failures++; $display("FAIL single_addr_last got=%0d want=2339", a[ADDR_W-1:0]);
        end
        checks++;
        if ({bus.draw_r, bus.draw_g, bus.draw_b} !== 12'h924) begin
            failures++; $display("FAIL single_rgb_last got=%h want=924", {bus.draw_r, bus.draw_g, bus.draw_b});
        end

        apply(11'd190, 11'd50, 1'b1, a);
        checks++;
        if (a[ADDR_W-1:0] !== 14'd2339) begin
            failures++; $display("FAIL single_addr_hold got=%0d want=2339", a[ADDR_W-1:0]);
        end
        checks++;
        if ({bus.draw_r, bus.draw_g, bus.draw_b} !== 12'h000) begin
            failures++; $display("FAIL single_right_edge got=%h want=000", {bus.draw_r, bus.draw_g, bus.draw_b});
        end

        apply(11'd100, 11'd76, 1'b1, a);
        checks++;
        if ({bus.draw_r, bus.draw_g, bus.draw_b} !== 12'h000) begin
            failures++; $display("FAIL single_bottom_edge got=%h want=000", {bus.draw_r, bus.draw_g, bus.draw_b});
        end
    endtask

    task automatic test_back_to_back();
        logic [PIX_W-1:0] exp_rgb [8];
        exp_rgb = '{12'h000, 12'h000, 12'h05B, 12'h05C, 12'h05D, 12'h05E, 12'h05F, 12'h060};
        bus.curr_y = 11'd51;
        for (int i = 0; i < 10; i++) begin
            bus.curr_x    = 11'(98 + i);
            bus.pix_valid = (i < 8);
            tick();
            if (i >= 2) begin
                checks++;
                if ({bus.draw_r, bus.draw_g, bus.draw_b, bus.draw_valid} !== {exp_rgb[i-2], 1'b1}) begin
                    failures++;
                    $display("FAIL stream_px%0d got=%h/%b want=%h/1", i - 2,
                             {bus.draw_r, bus.draw_g, bus.draw_b}, bus.draw_valid, exp_rgb[i-2]);
                end
            end
        end
        bus.pix_valid = 1'b0;
        tick();
    endtask

    task automatic test_background();
        logic [NUM_SPR*ADDR_W-1:0] a;
        logic [COORD_W-1:0] tx [9];
        logic [COORD_W-1:0] ty [9];
        logic               tv [9];
        logic [PIX_W-1:0]   te [9];
        tx = '{11'd5, 11'd1430, 11'd500, 11'd1429, 11'd9, 11'd10, 11'd500, 11'd500, 11'd5};
        ty = '{11'd5, 11'd100, 11'd500, 11'd100, 11'd500, 11'd500, 11'd889, 11'd890, 11'd5};
        tv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        te = '{12'hFFF, 12'hFFF, 12'h000, 12'h000, 12'hFFF, 12'h000, 12'h000, 12'hFFF, 12'h000};
        bus.spr_en = 4'b0000;
        pulse_frame();
        for (int k = 0; k < 9; k++) begin
            apply(tx[k], ty[k], tv[k], a);
            checks++;
            if ({bus.draw_r, bus.draw_g, bus.draw_b, bus.draw_valid} !== {te[k], tv[k]}) begin
                failures++;
                $display("FAIL bg_%0d_%0d_v%0d got=%h/%b want=%h/%b", tx[k], ty[k], tv[k],
                         {bus.draw_r, bus.draw_g, bus.draw_b}, bus.draw_valid, te[k], tv[k]);
            end
        end
    endtask

    task automatic test_tearing();
        logic [NUM_SPR*ADDR_W-1:0] a;
        set_pos(0, 11'd100, 11'd50);
        bus.spr_en = 4'b0001;
        pulse_frame();
        set_pos(0, 11'd300, 11'd50);

        apply(11'd100, 11'd50, 1'b1, a);
        checks++;
        if ({bus.draw_r, bus.draw_g, bus.draw_b} !== 12'h001) begin
            failures++; $display("FAIL tear_old_pos got=%h want=001", {bus.draw_r, bus.draw_g, bus.draw_b});
        end
        apply(11'd300, 11'd50, 1'b1, a);
        checks++;
        if ({bus.draw_r, bus.draw_g, bus.draw_b} !== 12'h000) begin
            failures++; $display("FAIL tear_new_early got=%h want=000", {bus.draw_r, bus.draw_g, bus.draw_b});
        end

        // frame_start while a pixel sits in S1: that pixel keeps the old position.
        bus.curr_x    = 11'd100;
        bus.curr_y    = 11'd50;
        bus.pix_valid = 1'b1;
        tick();
        bus.pix_valid   = 1'b0;
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        tick();
        checks++;
        if ({bus.draw_r, bus.draw_g, bus.draw_b} !== 12'h001) begin
            failures++; $display("FAIL tear_in_flight got=%h want=001", {bus.draw_r, bus.draw_g, bus.draw_b});
        end

        apply(11'd300, 11'd50, 1'b1, a);
        checks++;
        if ({bus.draw_r, bus.draw_g, bus.draw_b} !== 12'h001) begin
            failures++; $display("FAIL tear_new_pos got=%h want=001", {bus.draw_r, bus.draw_g, bus.draw_b});
        end
        apply(11'd100, 11'd50, 1'b1, a);
        checks++;
        if ({bus.draw_r, bus.draw_g, bus.draw_b} !== 12'h000) begin
            failures++; $display("FAIL tear_old_gone got=%h want=000", {bus.draw_r, bus.draw_g, bus.draw_b});
        end
    endtask

    task automatic test_priority();
        logic [NUM_SPR*ADDR_W-1:0] a;
        set_pos(0, 11'd200, 11'd200);
        set_pos(1, 11'd200, 11'd200);
        bus.spr_en    = 4'b0011;
        rom_mem[0][0] = 12'h000;
        rom_mem[1][0] = 12'hA5C;
        rom_mem[1][1] = 12'hABC;
        pulse_frame();

        apply(11'd200, 11'd200, 1'b1, a);
        checks++;
        if ({bus.draw_r, bus.draw_g, bus.draw_b} !== 12'hA5C) begin
            failures++; $display("FAIL prio_transparent got=%h want=A5C", {bus.draw_r, bus.draw_g, bus.draw_b});
        end
        rom_mem[0][0] = 12'h0F0;
        apply(11'd200, 11'd200, 1'b1, a);
        checks++;
        if ({bus.draw_r, bus.draw_g, bus.draw_b} !== 12'h0F0) begin
            failures++; $display("FAIL prio_opaque got=%h want=0F0", {bus.draw_r, bus.draw_g, bus.draw_b});
        end
        apply(11'd201, 11'd200, 1'b1, a);
        checks++;
        if ({bus.draw_r, bus.draw_g, bus.draw_b} !== 12'h002) begin
            failures++; $display("FAIL prio_low_index got=%h want=002", {bus.draw_r, bus.draw_g, bus.draw_b});
        end
    endtask

    task automatic test_collision();
        logic [NUM_SPR*ADDR_W-1:0] a;
        set_pos(0, 11'd400, 11'd400);
        set_pos(2, 11'd420, 11'd410);
        bus.spr_en = 4'b0101;
        pulse_frame();
        checks++;
        if (bus.coll_status !== 4'b0011) begin
            failures++; $display("FAIL coll_prev_prio got=%b want=0011", bus.coll_status);
        end

        apply(11'd430, 11'd415, 1'b1, a);
        checks++;
        if ({bus.draw_r, bus.draw_g, bus.draw_b} !== 12'h565) begin
            failures++; $display("FAIL coll_overlap_rgb got=%h want=565", {bus.draw_r, bus.draw_g, bus.draw_b});
        end
        set_pos(2, 11'd700, 11'd700);
        pulse_frame();
        checks++;
        if (bus.coll_status !== 4'b0101) begin
            failures++; $display("FAIL coll_frame_n got=%b want=0101", bus.coll_status);
        end

        apply(11'd430, 11'd415, 1'b1, a);
        checks++;
        if (bus.coll_status !== 4'b0101) begin
            failures++; $display("FAIL coll_midframe_hold got=%b want=0101", bus.coll_status);
        end
        set_pos(2, 11'd420, 11'd410);
        pulse_frame();
        checks++;
        if (bus.coll_status !== 4'b0000) begin
            failures++; $display("FAIL coll_frame_n1 got=%b want=0000", bus.coll_status);
        end

        // Overlap reaching S3 exactly in the frame_start cycle.
        bus.curr_x    = 11'd430;
        bus.curr_y    = 11'd415;
        bus.pix_valid = 1'b1;
        tick();
        bus.pix_valid = 1'b0;
        tick();
        pulse_frame();
        checks++;
        if (bus.coll_status !== 4'b0101) begin
            failures++; $display("FAIL coll_edge_cycle got=%b want=0101", bus.coll_status);
        end
        tick();
        pulse_frame();
        checks++;
        if (bus.coll_status !== 4'b0000) begin
            failures++; $display("FAIL coll_work_cleared got=%b want=0000", bus.coll_status);
        end
    endtask

    initial begin
        for (int i = 0; i < NUM_SPR; i++)
            for (int a = 0; a < DEPTH; a++)
                rom_mem[i][a] = PIX_W'(a + 1);
        rst             = 1'b0;
        bus.frame_start = 1'b0;
        bus.spr_en      = '0;
        bus.spr_pos_x   = '0;
        bus.spr_pos_y   = '0;
        bus.curr_x      = '0;
        bus.curr_y      = '0;
        bus.pix_valid   = 1'b0;

        test_reset();
        test_single_sprite();
        test_back_to_back();
        test_background();
        test_tearing();
        test_priority();
        test_collision();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
